// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous RAM port between the CPU MEM stage and an aux requester.
// Rev 1.0 - CPU-priority arbitration with an anti-starvation wait counter and read-return steering.
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int AUX_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_gnt,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  output logic                  aux_rvalid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] c_MAX_WAIT = 4'(AUX_MAX_WAIT);

  logic                  w_aux_win;
  logic                  w_cpu_win;
  logic [3:0]            wait_cnt_q,    wait_cnt_d;
  logic                  cpu_rd_pend_q, cpu_rd_pend_d;
  logic                  aux_rd_pend_q, aux_rd_pend_d;
  logic [DATA_WIDTH-1:0] cpu_rhold_q,   cpu_rhold_d;
  logic [DATA_WIDTH-1:0] aux_rhold_q,   aux_rhold_d;

  // Aux only beats a simultaneous CPU request once it has been denied AUX_MAX_WAIT times in a row.
  always_comb begin
    w_aux_win = aux_req & (~cpu_req | (wait_cnt_q == c_MAX_WAIT));
    w_cpu_win = cpu_req & ~w_aux_win;
  end

  always_comb begin
    ram_en    = w_cpu_win | w_aux_win;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_cpu_win) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (w_aux_win) begin
      ram_we    = aux_we;
      ram_addr  = aux_addr;
      ram_wdata = aux_wdata;
    end
    cpu_stall = cpu_req & ~w_cpu_win;
    aux_gnt   = w_aux_win;
  end

  always_comb begin
    wait_cnt_d = '0;
    if (aux_req && !w_aux_win) begin
      wait_cnt_d = (wait_cnt_q < c_MAX_WAIT) ? wait_cnt_q + 4'd1 : wait_cnt_q;
    end
    cpu_rd_pend_d = w_cpu_win & ~cpu_we;
    aux_rd_pend_d = w_aux_win & ~aux_we;
    // Returning data is latched so each requester keeps seeing its own last read.
    cpu_rhold_d   = cpu_rd_pend_q ? ram_rdata : cpu_rhold_q;
    aux_rhold_d   = aux_rd_pend_q ? ram_rdata : aux_rhold_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt_q    <= '0;
      cpu_rd_pend_q <= 1'b0;
      aux_rd_pend_q <= 1'b0;
      cpu_rhold_q   <= '0;
      aux_rhold_q   <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      aux_rd_pend_q <= aux_rd_pend_d;
      cpu_rhold_q   <= cpu_rhold_d;
      aux_rhold_q   <= aux_rhold_d;
    end
  end

  always_comb begin
    cpu_rvalid = cpu_rd_pend_q;
    aux_rvalid = aux_rd_pend_q;
    cpu_rdata  = cpu_rd_pend_q ? ram_rdata : cpu_rhold_q;
    aux_rdata  = aux_rd_pend_q ? ram_rdata : aux_rhold_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scenario tasks plus a read-return scoreboard around ram_port_arbiter.
`default_nettype none

module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] cpu_q [$];
  logic [31:0] aux_q [$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .AUX_MAX_WAIT(4)) dut (
    .clk(clk), .clr(clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Synchronous RAM model: read data appears the cycle after the read is issued.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else        ram_rdata <= mem_rd(ram_addr);
    end
  end

  // Scoreboard: expected read data is queued on the issuing cycle and matched against rvalid.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (clr) begin
      cpu_q.delete();
      aux_q.delete();
      checks++;
      if (cpu_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL sb_rvalid_in_reset: cpu_rvalid=%b aux_rvalid=%b required 0/0", cpu_rvalid, aux_rvalid);
      end
    end else begin
      checks++;
      if (cpu_rvalid !== (cpu_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_cpu_rvalid: got %b required %b", cpu_rvalid, cpu_q.size() != 0);
      end
      if (cpu_q.size() != 0) begin
        exp = cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== exp) begin
          failures++;
          $display("FAIL sb_cpu_rdata: got %h required %h", cpu_rdata, exp);
        end
      end
      checks++;
      if (aux_rvalid !== (aux_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_aux_rvalid: got %b required %b", aux_rvalid, aux_q.size() != 0);
      end
      if (aux_q.size() != 0) begin
        exp = aux_q.pop_front();
        checks++;
        if (aux_rdata !== exp) begin
          failures++;
          $display("FAIL sb_aux_rdata: got %h required %h", aux_rdata, exp);
        end
      end
      if (cpu_req && !cpu_stall && !cpu_we) cpu_q.push_back(mem_rd(cpu_addr));
      if (aux_gnt && !aux_we)               aux_q.push_back(mem_rd(aux_addr));
    end
  end

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_aux(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem[32'h40] = 32'h55;
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    next_cycle();
    // read now pending; assert reset on top of it with both requesters active
    clr = 1'b1;
    set_aux(1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_cpu_read: rvalid=%b rdata=%h required 0/00000000", cpu_rvalid, cpu_rdata);
    end
    checks++;
    if (aux_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait_cnt_zero: aux_gnt=%b cpu_stall=%b ram_en=%b required 0/0/1", aux_gnt, cpu_stall, ram_en);
    end
    next_cycle();
    clr = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0 || cpu_rvalid !== 1'b0 || aux_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_idle: ram_en=%b cpu_rvalid=%b aux_rvalid=%b cpu_rdata=%h required 0/0/0/0", ram_en, cpu_rvalid, aux_rvalid, cpu_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_cpu_only();
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL cpu_write: en=%b we=%b addr=%h wdata=%h stall=%b required 1/1/10/deadbeef/0", ram_en, ram_we, ram_addr, ram_wdata, cpu_stall);
    end
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_issue: we=%b stall=%b rvalid=%b required 0/0/0", ram_we, cpu_stall, cpu_rvalid);
    end
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_return: rvalid=%b rdata=%h stall=%b required 1/deadbeef/0", cpu_rvalid, cpu_rdata, cpu_stall);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL cpu_rdata_hold: rvalid=%b rdata=%h required 0/deadbeef", cpu_rvalid, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_aux;
    set_cpu(1'b1, 1'b1, 32'h100, 32'hC0);
    set_aux(1'b1, 1'b1, 32'h200, 32'hA0);
    for (int i = 0; i < 10; i++) begin
      exp_aux = (i == 4) || (i == 9);
      @(negedge clk);
      checks++;
      if (aux_gnt !== exp_aux || cpu_stall !== exp_aux || ram_addr !== (exp_aux ? 32'h200 : 32'h100)) begin
        failures++;
        $display("FAIL contention_cycle%0d: aux_gnt=%b cpu_stall=%b ram_addr=%h required %b/%b/%h", i, aux_gnt, cpu_stall, ram_addr, exp_aux, exp_aux, exp_aux ? 32'h200 : 32'h100);
      end
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_routing();
    mem[32'h20] = 32'h11;
    mem[32'h24] = 32'h22;
    set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    next_cycle();
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b1, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h11 || aux_rvalid !== 1'b0 || aux_gnt !== 1'b1) begin
      failures++;
      $display("FAIL routing_n1: cpu_rvalid=%b cpu_rdata=%h aux_rvalid=%b aux_gnt=%b required 1/11/0/1", cpu_rvalid, cpu_rdata, aux_rvalid, aux_gnt);
    end
    next_cycle();
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (aux_rvalid !== 1'b1 || aux_rdata !== 32'h22 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h11) begin
      failures++;
      $display("FAIL routing_n2: aux_rvalid=%b aux_rdata=%h cpu_rvalid=%b cpu_rdata=%h required 1/22/0/11", aux_rvalid, aux_rdata, cpu_rvalid, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_aux_withdraw();
    logic exp_aux;
    set_cpu(1'b1, 1'b1, 32'h300, 32'h1);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) set_aux(1'b0, 1'b1, 32'h304, 32'h2);
      else        set_aux(1'b1, 1'b1, 32'h304, 32'h2);
      exp_aux = (i == 8);
      @(negedge clk);
      checks++;
      if (aux_gnt !== exp_aux || cpu_stall !== exp_aux) begin
        failures++;
        $display("FAIL withdraw_cycle%0d: aux_gnt=%b cpu_stall=%b required %b/%b", i, aux_gnt, cpu_stall, exp_aux, exp_aux);
      end
      next_cycle();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset_during_read();
    mem[32'h30] = 32'h77;
    set_aux(1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    checks++;
    if (aux_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_read_grant: aux_gnt=%b required 1", aux_gnt);
    end
    next_cycle();
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    clr = 1'b1;
    @(negedge clk);
    next_cycle();
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (aux_rvalid !== 1'b0 || aux_rdata !== 32'h0) begin
        failures++;
        $display("FAIL rst_read_discard%0d: aux_rvalid=%b aux_rdata=%h required 0/00000000", i, aux_rvalid, aux_rdata);
      end
      next_cycle();
    end
  endtask

  initial begin
    clr = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_aux(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    clr = 1'b0;
    next_cycle();
    test_reset();
    test_cpu_only();
    test_contention();
    test_routing();
    test_aux_withdraw();
    test_reset_during_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
